// File: rtl/if1_align_skid.sv
// Fetch stage 1: aligns the I-cache line by PC offset into a left-packed group and pushes it to the
// instruction buffer, parking unpushed remainders in an in-order skid FIFO of whole lines.
module if1_align_skid #(
    parameter  int FETCH_W    = 4,
    parameter  int IB_W_LOG2  = 4,
    parameter  int SKID_DEPTH = 2,
    parameter  int ENT_WD     = 66,
    localparam int OFS_W      = $clog2(FETCH_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_IF,
    input  logic                      if0_valid,
    output logic                      if1_ready,
    input  logic [31:0]               if0_pc,
    input  logic [FETCH_W-1:0]        if0_pc_valid,
    input  logic [FETCH_W-1:0]        if0_pc_is_jump,
    input  logic                      data_ok,
    input  logic [32*FETCH_W-1:0]     rdata,
    input  logic [IB_W_LOG2:0]        can_push_size,
    output logic [OFS_W:0]            push_num,
    output logic [ENT_WD*FETCH_W-1:0] if1_to_ib
);
    localparam int NW    = OFS_W + 1;
    localparam int CPS_W = IB_W_LOG2 + 1;
    localparam int MW    = (CPS_W > NW) ? CPS_W : NW;
    localparam int PW    = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW    = $clog2(SKID_DEPTH + 1);
    localparam int CW1   = CW + 1;
    localparam int LW    = ENT_WD * FETCH_W;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    // min(remaining, free, FETCH_W) evaluated wide enough that can_push_size is never truncated
    function automatic logic [NW-1:0] clamp_push(input logic [NW-1:0] rem, input logic [CPS_W-1:0] cps);
        logic [MW-1:0] r, c, m;
        r = MW'(rem);
        c = MW'(cps);
        m = (c < r) ? c : r;
        if (m > MW'(FETCH_W)) m = MW'(FETCH_W);
        return NW'(m);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t               state, state_next;
    logic [31:0]          req_pc;
    logic [FETCH_W-1:0]   req_vld, req_jmp;
    logic                 accept;

    logic [31:0]          src_pc;
    logic [FETCH_W-1:0]   src_vld, src_jmp;
    logic [OFS_W-1:0]     arr_off;
    logic [NW-1:0]        arr_n;
    logic [LW-1:0]        arr_line;
    logic                 arr_vld;

    logic [LW-1:0]        skid_line [SKID_DEPTH];
    logic [NW-1:0]        skid_n    [SKID_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        skid_cnt;
    logic [OFS_W-1:0]     head_ptr;

    logic                 skid_ne, pop, enq, arr_cand, enq_cand;
    logic [NW-1:0]        skid_rem, skid_push, head_rem, push_eff;
    logic [CW1-1:0]       cnt_cand;
    logic [LW-1:0]        head_line;
    logic [OFS_W-1:0]     head_base;

    // Same-cycle hit uses live request fields; a late response uses the fields latched at acceptance
    always_comb begin
        src_pc   = (state == IDLE) ? if0_pc         : req_pc;
        src_vld  = (state == IDLE) ? if0_pc_valid   : req_vld;
        src_jmp  = (state == IDLE) ? if0_pc_is_jump : req_jmp;
        arr_off  = src_pc[OFS_W+1:2];
        arr_n    = NW'(FETCH_W) - NW'(arr_off);
        arr_line = '0;
        for (int j = 0; j < FETCH_W; j++) begin
            if (NW'(j) < arr_n)
                arr_line[ENT_WD*j +: ENT_WD] = ENT_WD'({src_vld[arr_off + OFS_W'(j)],
                                                        src_jmp[arr_off + OFS_W'(j)],
                                                        src_pc + 32'(4 * j),
                                                        rdata[32*(arr_off + OFS_W'(j)) +: 32]});
        end
    end

    // Readiness looks ahead at the occupancy this cycle would leave, without depending on accept
    always_comb begin
        skid_ne   = (skid_cnt != '0);
        skid_rem  = skid_n[rd_ptr] - NW'(head_ptr);
        skid_push = clamp_push(skid_rem, can_push_size);
        pop       = skid_ne && !rst && !flush_IF && (skid_push == skid_rem);
        arr_cand  = data_ok && (state == WAIT || (state == IDLE && if0_valid));
        enq_cand  = arr_cand && (skid_ne || (clamp_push(arr_n, can_push_size) < arr_n));
        cnt_cand  = CW1'(skid_cnt) - CW1'(pop) + CW1'(enq_cand);
        if1_ready = !rst && !flush_IF && (state == IDLE || (state == WAIT && data_ok))
                    && (cnt_cand < CW1'(SKID_DEPTH));
    end

    always_comb begin
        accept    = if0_valid && if1_ready;
        arr_vld   = !rst && !flush_IF && data_ok && (state == WAIT || (state == IDLE && accept));
        head_line = '0;
        head_rem  = '0;
        head_base = '0;
        if (skid_ne) begin
            head_line = skid_line[rd_ptr];
            head_rem  = skid_rem;
            head_base = head_ptr;
        end else if (arr_vld) begin
            head_line = arr_line;
            head_rem  = arr_n;
        end
        push_eff  = (rst || flush_IF) ? '0 : clamp_push(head_rem, can_push_size);
        enq       = arr_vld && (skid_ne || (push_eff < arr_n));
        push_num  = push_eff;
        if1_to_ib = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (NW'(i) < push_eff)
                if1_to_ib[ENT_WD*i +: ENT_WD] = head_line[ENT_WD*(head_base + OFS_W'(i)) +: ENT_WD];
        end
    end

    // A new request accepted alongside the old response stays outstanding, so WAIT is kept
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !data_ok) state_next = WAIT;
            WAIT:    if (data_ok)       state_next = accept ? WAIT : IDLE;
                     else if (flush_IF) state_next = DROP;
            DROP:    if (data_ok)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skid_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            head_ptr <= '0;
        end else begin
            state <= state_next;
            if (flush_IF) begin
                skid_cnt <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                head_ptr <= '0;
            end else begin
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                if (enq) wr_ptr <= ptr_inc(wr_ptr);
                skid_cnt <= skid_cnt - CW'(pop) + CW'(enq);
                if (pop)          head_ptr <= '0;
                else if (skid_ne) head_ptr <= head_ptr + OFS_W'(push_eff);
                else if (enq)     head_ptr <= OFS_W'(push_eff);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc  <= if0_pc;
            req_vld <= if0_pc_valid;
            req_jmp <= if0_pc_is_jump;
        end
        if (enq) begin
            skid_line[wr_ptr] <= arr_line;
            skid_n[wr_ptr]    <= arr_n;
        end
    end
endmodule
